// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: simple-dual-port storage, registered read with valid strobe,
// occupancy count, threshold flags, sticky error flags and synchronous flush.
module sync_fifo_ctrl #(
   parameter int WIDTH    = 8,
   parameter int ADDR     = 10,
   parameter int AF_LEVEL = 1020,
   parameter int AE_LEVEL = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic [ADDR:0]     count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH   = 1 << ADDR;
   localparam logic [ADDR:0]   DEPTH_C = (ADDR+1)'(DEPTH);
   localparam logic [ADDR:0]   AF_C    = (ADDR+1)'(AF_LEVEL);
   localparam logic [ADDR:0]   AE_C    = (ADDR+1)'(AE_LEVEL);
   localparam logic [ADDR:0]   CNT_ONE = (ADDR+1)'(1);
   localparam logic [ADDR-1:0] PTR_ONE = ADDR'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ADDR-1:0]  wp;
   logic [ADDR-1:0]  rp;
   logic             wr_ok;
   logic             rd_ok;

   // Flags come straight off the count register, so they track it exactly.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign wr_ok = wr_en && !full  && !clear;
   assign rd_ok = rd_en && !empty && !clear;

   // Storage is deliberately not reset; reads only target written slots.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wp <= wp + PTR_ONE;
         if (rd_ok) rp <= rp + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // rd_data survives a flush; only the strobe is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) rd_data <= mem[rp];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)  overflow  <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: read data checked by a scoreboard monitor,
// status outputs checked inline against hand-computed values.
module tb_sync_fifo_ctrl;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [10:0] count;
   logic        full, empty, almost_full, almost_empty, overflow, underflow;

   int vectors     = 0;
   int miscompares = 0;
   int mon_vectors = 0;
   int mon_miscompares = 0;

   logic [7:0] exp_q [$];
   logic [7:0] mq [$];
   logic [7:0] last_exp = 8'h00;

   sync_fifo_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Every accepted read must surface as exactly one rd_valid cycle, in order.
   always @(negedge clk) begin
      if (reset_n) begin
         if (rd_valid) begin
            mon_vectors++;
            if (exp_q.size() == 0) begin
               mon_miscompares++;
               $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%02h, required no pop", rd_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  mon_miscompares++;
                  $display("FAIL rd_data: got %02h required %02h", rd_data, e);
               end
            end
         end else if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            mon_vectors++;
            mon_miscompares++;
            $display("FAIL rd_valid_missing: got rd_valid=0, required data %02h", e);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; acc_rd/acc_wr are the hand-decided acceptance results.
   task automatic xfer(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input logic acc_rd, input logic acc_wr);
      wr_en = w; wr_data = d; rd_en = r; clear = c;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
      if (acc_rd) begin
         last_exp = mq.pop_front();
         exp_q.push_back(last_exp);
      end
      if (acc_wr) mq.push_back(d);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_data"},   32'(rd_data), 32'h0);
      check({tag, "_rd_valid"},  32'(rd_valid), 32'h0);
      check({tag, "_count"},     32'(count), 32'h0);
      check({tag, "_empty"},     32'(empty), 32'h1);
      check({tag, "_full"},      32'(full), 32'h0);
      check({tag, "_ae"},        32'(almost_empty), 32'h1);
      check({tag, "_af"},        32'(almost_full), 32'h0);
      check({tag, "_overflow"},  32'(overflow), 32'h0);
      check({tag, "_underflow"}, 32'(underflow), 32'h0);
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      #3;
      check_reset_vals("reset");
      #9 reset_n = 1'b1;

      // Basic in-order write/read of five words.
      for (int i = 1; i <= 5; i++) begin
         xfer(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 4) check("ae_at_4", 32'(almost_empty), 32'h1);
      end
      check("count_5", 32'(count), 32'd5);
      check("ae_at_5", 32'(almost_empty), 32'h0);
      check("empty_at_5", 32'(empty), 32'h0);
      for (int i = 0; i < 5; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("count_drained", 32'(count), 32'd0);
      check("empty_drained", 32'(empty), 32'h1);

      // Fill to full, watching almost_full threshold.
      for (int i = 0; i < 1024; i++) begin
         xfer(1'b1, 8'(i) ^ 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 1018) check("af_at_1019", 32'(almost_full), 32'h0);
         if (i == 1019) check("af_at_1020", 32'(almost_full), 32'h1);
         if (i == 1022) check("full_at_1023", 32'(full), 32'h0);
      end
      check("count_full", 32'(count), 32'd1024);
      check("full", 32'(full), 32'h1);
      check("ovf_before", 32'(overflow), 32'h0);
      xfer(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check("count_after_ovf", 32'(count), 32'd1024);
      check("overflow_set", 32'(overflow), 32'h1);
      xfer(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("overflow_sticky", 32'(overflow), 32'h1);

      // Simultaneous read+write at full: read wins, write dropped.
      xfer(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
      check("count_full_rw", 32'(count), 32'd1023);
      check("full_rw_full", 32'(full), 32'h0);
      check("full_rw_ovf", 32'(overflow), 32'h1);
      for (int i = 0; i < 1023; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("count_drain_full", 32'(count), 32'd0);

      // Simultaneous read+write at empty: write wins, no bypass.
      xfer(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
      check("underflow_set", 32'(underflow), 32'h1);
      check("count_empty_rw", 32'(count), 32'd1);
      check("no_valid_empty_rw", 32'(rd_valid), 32'h0);
      xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("underflow_sticky", 32'(underflow), 32'h1);
      xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      check("clear_ovf", 32'(overflow), 32'h0);
      check("clear_udf", 32'(underflow), 32'h0);

      // Pointer wrap: 300 through, then 1000 more with 995 simultaneous cycles.
      for (int i = 0; i < 300; i++) xfer(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0, 1'b0, 1'b1);
      check("count_300", 32'(count), 32'd300);
      for (int i = 0; i < 300; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) xfer(1'b1, 8'(i * 13 + 1), 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 5; i < 1000; i++) xfer(1'b1, 8'(i * 13 + 1), 1'b1, 1'b0, 1'b1, 1'b1);
      check("count_wrap_5", 32'(count), 32'd5);
      check("ae_wrap_5", 32'(almost_empty), 32'h0);
      xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("ae_wrap_4", 32'(almost_empty), 32'h1);
      for (int i = 0; i < 4; i++) xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("count_wrap_0", 32'(count), 32'd0);

      // Flush with wr_en and rd_en asserted in the clear cycle.
      xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      check("udf_pre_clear", 32'(underflow), 32'h1);
      for (int i = 0; i < 10; i++) xfer(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      check("count_10", 32'(count), 32'd10);
      xfer(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
      mq.delete();
      check("clr_count", 32'(count), 32'd0);
      check("clr_empty", 32'(empty), 32'h1);
      check("clr_ovf", 32'(overflow), 32'h0);
      check("clr_udf", 32'(underflow), 32'h0);
      check("clr_rd_valid", 32'(rd_valid), 32'h0);
      check("clr_rd_data_kept", 32'(rd_data), 32'(last_exp));

      // Asynchronous reset in the middle of a read/write burst.
      for (int i = 0; i < 3; i++) xfer(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b1);
      wr_en = 1'b1; wr_data = 8'h11; rd_en = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      mq.delete();
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;

      xfer(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
      check("post_reset_count", 32'(count), 32'd1);
      xfer(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) xfer(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      vectors     += mon_vectors;
      miscompares += mon_miscompares;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
